// File: rtl/irq_sequencer_pkg.sv
// Shared types and constants for the interrupt entry/exit sequencer.
// Holds the FSM state encoding, CSR indices and mstatus field layout.
package irq_sequencer_pkg;

    localparam int unsigned HOLDOFF_W   = 4;
    localparam int unsigned CSR_SEL_W   = 2;
    localparam int unsigned MSTATUS_MIE  = 0;
    localparam int unsigned MSTATUS_MPIE = 1;

    localparam logic [CSR_SEL_W-1:0] CSR_MSTATUS = 2'd0;
    localparam logic [CSR_SEL_W-1:0] CSR_MEPC    = 2'd1;
    localparam logic [CSR_SEL_W-1:0] CSR_MCAUSE  = 2'd2;
    localparam logic [CSR_SEL_W-1:0] CSR_MTARGET = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_VECTOR = 3'd2,
        ST_ISR    = 3'd3,
        ST_RETURN = 3'd4
    } state_e;

    // Bit order matches MSTATUS_MPIE / MSTATUS_MIE positions
    typedef struct packed {
        logic mpie;
        logic mie;
    } mstatus_t;

endpackage

// File: rtl/irq_holdoff_cnt.sv
// Loadable saturating down-counter; o_zero is high when the count is zero.
module irq_holdoff_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_zero;

    // Load wins; otherwise count down and stick at zero
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_load) begin
            w_cnt_nxt = i_load_val;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_zero <= 1'b1;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_zero <= (w_cnt_nxt == '0);
        end
    end

    assign o_zero = r_zero;

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer: drains to an instruction boundary, vectors,
// tracks handler execution and returns, maintaining mstatus/mepc/mcause/mtarget.
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              irq,
    input  logic [ADDR_W-1:0] isr_addr,
    input  logic [1:0]        priority_select,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              instr_retire,
    input  logic              mret,
    input  logic              csr_we,
    input  logic [1:0]        csr_sel,
    input  logic [ADDR_W-1:0] csr_wdata,
    output logic [ADDR_W-1:0] csr_rdata,
    output logic              iack,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic              stall_fetch,
    output logic              in_isr
);

    state_e            r_state;
    state_e            w_state_nxt;

    mstatus_t          r_mstatus;
    logic [ADDR_W-1:0] r_mepc;
    logic [ADDR_W-1:0] r_mcause;
    logic [ADDR_W-1:0] r_mtarget;

    mstatus_t          w_mstatus_nxt;
    logic [ADDR_W-1:0] w_mepc_nxt;
    logic [ADDR_W-1:0] w_mcause_nxt;
    logic [ADDR_W-1:0] w_mtarget_nxt;

    logic              w_hold_load;
    logic              w_hold_zero;

    logic              r_iack;
    logic              r_redirect;
    logic [ADDR_W-1:0] r_redirect_addr;
    logic              r_stall;
    logic              r_in_isr;

    irq_holdoff_cnt #(
        .CNT_W (HOLDOFF_W)
    ) u_holdoff (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_hold_load),
        .i_load_val (HOLDOFF_W'(HOLDOFF)),
        .o_zero     (w_hold_zero)
    );

    // Next state and CSR updates; hardware updates are applied after software writes
    always_comb begin
        w_state_nxt   = r_state;
        w_mstatus_nxt = r_mstatus;
        w_mepc_nxt    = r_mepc;
        w_mcause_nxt  = r_mcause;
        w_mtarget_nxt = r_mtarget;
        w_hold_load   = 1'b0;

        if (csr_we) begin
            case (csr_sel)
                CSR_MSTATUS: begin
                    w_mstatus_nxt.mie  = csr_wdata[MSTATUS_MIE];
                    w_mstatus_nxt.mpie = csr_wdata[MSTATUS_MPIE];
                end
                CSR_MEPC:   w_mepc_nxt   = csr_wdata;
                CSR_MCAUSE: w_mcause_nxt = csr_wdata;
                default: ;
            endcase
        end

        case (r_state)
            ST_IDLE: begin
                if (irq && r_mstatus.mie && w_hold_zero) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!irq || !r_mstatus.mie) begin
                    w_state_nxt = ST_IDLE;
                end else if (instr_retire) begin
                    w_state_nxt        = ST_VECTOR;
                    w_mepc_nxt         = pc_next;
                    w_mcause_nxt       = ADDR_W'(priority_select);
                    w_mtarget_nxt      = isr_addr;
                    w_mstatus_nxt.mpie = r_mstatus.mie;
                    w_mstatus_nxt.mie  = 1'b0;
                end
            end
            ST_VECTOR: begin
                w_state_nxt = ST_ISR;
                w_hold_load = 1'b1;
            end
            ST_ISR: begin
                if (mret) begin
                    w_state_nxt = ST_RETURN;
                end
            end
            ST_RETURN: begin
                w_state_nxt        = ST_IDLE;
                w_hold_load        = 1'b1;
                w_mstatus_nxt.mie  = r_mstatus.mpie;
                w_mstatus_nxt.mpie = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mstatus <= '0;
            r_mepc    <= '0;
            r_mcause  <= '0;
            r_mtarget <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mstatus <= w_mstatus_nxt;
            r_mepc    <= w_mepc_nxt;
            r_mcause  <= w_mcause_nxt;
            r_mtarget <= w_mtarget_nxt;
        end
    end

    // Outputs registered from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iack          <= 1'b0;
            r_redirect      <= 1'b0;
            r_redirect_addr <= '0;
            r_stall         <= 1'b0;
            r_in_isr        <= 1'b0;
        end else begin
            r_iack     <= (w_state_nxt == ST_VECTOR);
            r_redirect <= (w_state_nxt == ST_VECTOR) || (w_state_nxt == ST_RETURN);
            r_stall    <= (w_state_nxt == ST_DRAIN);
            r_in_isr   <= (w_state_nxt == ST_ISR);
            if (w_state_nxt == ST_VECTOR) begin
                r_redirect_addr <= w_mtarget_nxt;
            end else if (w_state_nxt == ST_RETURN) begin
                r_redirect_addr <= w_mepc_nxt;
            end else begin
                r_redirect_addr <= '0;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_sel)
            CSR_MSTATUS: csr_rdata = ADDR_W'(r_mstatus);
            CSR_MEPC:    csr_rdata = r_mepc;
            CSR_MCAUSE:  csr_rdata = r_mcause;
            CSR_MTARGET: csr_rdata = r_mtarget;
            default:     csr_rdata = '0;
        endcase
    end

    assign iack          = r_iack;
    assign pc_redirect   = r_redirect;
    assign redirect_addr = r_redirect_addr;
    assign stall_fetch   = r_stall;
    assign in_isr        = r_in_isr;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed and randomized bench for irq_sequencer against a cycle-level
// behavioural model of the take / handler / return sequence.
module tb_irq_sequencer;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned HOLDOFF = 2;

    localparam int M_IDLE  = 0;
    localparam int M_DRAIN = 1;
    localparam int M_VEC   = 2;
    localparam int M_ISR   = 3;
    localparam int M_RET   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              irq = 1'b0;
    logic [ADDR_W-1:0] isr_addr = '0;
    logic [1:0]        priority_select = '0;
    logic [ADDR_W-1:0] pc_next = '0;
    logic              instr_retire = 1'b0;
    logic              mret = 1'b0;
    logic              csr_we = 1'b0;
    logic [1:0]        csr_sel = '0;
    logic [ADDR_W-1:0] csr_wdata = '0;
    logic [ADDR_W-1:0] csr_rdata;
    logic              iack;
    logic              pc_redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              stall_fetch;
    logic              in_isr;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_mode;
    int          m_hold;
    logic        m_mie;
    logic        m_mpie;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;
    logic [31:0] m_mtarget;

    logic [31:0] rnd_epc;

    always #5 clk = ~clk;

    irq_sequencer #(
        .ADDR_W  (ADDR_W),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .irq             (irq),
        .isr_addr        (isr_addr),
        .priority_select (priority_select),
        .pc_next         (pc_next),
        .instr_retire    (instr_retire),
        .mret            (mret),
        .csr_we          (csr_we),
        .csr_sel         (csr_sel),
        .csr_wdata       (csr_wdata),
        .csr_rdata       (csr_rdata),
        .iack            (iack),
        .pc_redirect     (pc_redirect),
        .redirect_addr   (redirect_addr),
        .stall_fetch     (stall_fetch),
        .in_isr          (in_isr)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", name, $time, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_csr(input logic [1:0] sel);
        case (sel)
            2'd0:    return {30'b0, m_mpie, m_mie};
            2'd1:    return m_mepc;
            2'd2:    return m_mcause;
            default: return m_mtarget;
        endcase
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_hold    = 0;
        m_mie     = 1'b0;
        m_mpie    = 1'b0;
        m_mepc    = '0;
        m_mcause  = '0;
        m_mtarget = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        int          nm;
        int          nh;
        logic        nmie;
        logic        nmpie;
        logic [31:0] nepc;
        logic [31:0] ncause;
        logic [31:0] ntgt;
        nm = m_mode; nmie = m_mie; nmpie = m_mpie;
        nepc = m_mepc; ncause = m_mcause; ntgt = m_mtarget;
        nh = (m_hold > 0) ? m_hold - 1 : 0;
        if (csr_we) begin
            if (csr_sel == 2'd0) begin
                nmie  = csr_wdata[0];
                nmpie = csr_wdata[1];
            end else if (csr_sel == 2'd1) begin
                nepc = csr_wdata;
            end else if (csr_sel == 2'd2) begin
                ncause = csr_wdata;
            end
        end
        if (m_mode == M_IDLE) begin
            if (irq && m_mie && m_hold == 0) nm = M_DRAIN;
        end else if (m_mode == M_DRAIN) begin
            if (!irq || !m_mie) begin
                nm = M_IDLE;
            end else if (instr_retire) begin
                nm = M_VEC;
                nepc = pc_next;
                ncause = {30'b0, priority_select};
                ntgt = isr_addr;
                nmpie = m_mie;
                nmie = 1'b0;
            end
        end else if (m_mode == M_VEC) begin
            nm = M_ISR;
            nh = HOLDOFF;
        end else if (m_mode == M_ISR) begin
            if (mret) nm = M_RET;
        end else begin
            nm = M_IDLE;
            nh = HOLDOFF;
            nmie = m_mpie;
            nmpie = 1'b1;
        end
        m_mode = nm; m_hold = nh; m_mie = nmie; m_mpie = nmpie;
        m_mepc = nepc; m_mcause = ncause; m_mtarget = ntgt;
    endtask

    task automatic check_all();
        logic [31:0] exp_addr;
        exp_addr = (m_mode == M_VEC) ? m_mtarget : ((m_mode == M_RET) ? m_mepc : 32'h0);
        chk("iack",          32'(iack),          32'(m_mode == M_VEC));
        chk("pc_redirect",   32'(pc_redirect),   32'(m_mode == M_VEC || m_mode == M_RET));
        chk("redirect_addr", redirect_addr,      exp_addr);
        chk("stall_fetch",   32'(stall_fetch),   32'(m_mode == M_DRAIN));
        chk("in_isr",        32'(in_isr),        32'(m_mode == M_ISR));
        chk("csr_rdata",     csr_rdata,          model_csr(csr_sel));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic csr_expect(input logic [1:0] sel, input logic [31:0] exp, input string name);
        csr_sel = sel;
        #1;
        chk(name, csr_rdata, exp);
    endtask

    task automatic csr_write(input logic [1:0] sel, input logic [31:0] data);
        csr_we = 1'b1; csr_sel = sel; csr_wdata = data;
        tick();
        csr_we = 1'b0; csr_wdata = '0;
    endtask

    initial begin
        do_reset();
        csr_expect(2'd0, 32'h0, "reset_mstatus");
        csr_expect(2'd1, 32'h0, "reset_mepc");

        // Masked: irq held with MIE=0, then enable
        isr_addr = 32'h100; priority_select = 2'd2; pc_next = 32'h40; irq = 1'b1;
        repeat (20) tick();
        csr_write(2'd0, 32'h1);
        tick();
        chk("take_stall", 32'(stall_fetch), 32'h1);

        // Take after three drain cycles
        tick();
        tick();
        chk("drain_stall3", 32'(stall_fetch), 32'h1);
        instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
        chk("take_iack", 32'(iack), 32'h1);
        chk("take_redirect_addr", redirect_addr, 32'h100);
        tick();
        chk("take_iack_one_cycle", 32'(iack), 32'h0);
        csr_expect(2'd1, 32'h40, "take_mepc");
        csr_expect(2'd2, 32'h2, "take_mcause");
        csr_expect(2'd0, 32'h2, "take_mstatus");
        csr_expect(2'd3, 32'h100, "take_mtarget");

        // Handler ignores irq, then return and holdoff
        repeat (3) tick();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("ret_redirect", 32'(pc_redirect), 32'h1);
        chk("ret_addr", redirect_addr, 32'h40);
        tick();
        csr_expect(2'd0, 32'h3, "ret_mstatus");
        tick();
        chk("holdoff_1", 32'(stall_fetch), 32'h0);
        tick();
        chk("holdoff_2", 32'(stall_fetch), 32'h0);
        tick();
        chk("retake", 32'(stall_fetch), 32'h1);

        // Abort by irq drop, then by MIE clear
        irq = 1'b0;
        tick();
        csr_expect(2'd1, 32'h40, "abort_mepc");
        irq = 1'b1;
        tick();
        csr_write(2'd0, 32'h0);
        tick();
        chk("abort_mie", 32'(stall_fetch), 32'h0);
        csr_write(2'd0, 32'h1);
        tick();

        // Collision: software write to mstatus on the vectoring edge
        isr_addr = $urandom; pc_next = $urandom; priority_select = 2'($urandom_range(0, 3));
        instr_retire = 1'b1; csr_we = 1'b1; csr_sel = 2'd0; csr_wdata = 32'h1;
        tick();
        instr_retire = 1'b0; csr_we = 1'b0; csr_wdata = '0;
        csr_expect(2'd0, 32'h2, "collision_mstatus");
        tick();
        rnd_epc = $urandom;
        csr_write(2'd1, rnd_epc);
        csr_write(2'd3, 32'hDEAD_BEEF);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("ret_written_mepc", redirect_addr, rnd_epc);
        tick();

        // Stray mret outside handler
        irq = 1'b0; mret = 1'b1;
        repeat (5) tick();
        mret = 1'b0;

        // Reset in the middle of a handler
        irq = 1'b1; instr_retire = 1'b1;
        for (int i = 0; i < 20 && m_mode != M_ISR; i++) tick();
        chk("reached_isr", 32'(in_isr), 32'h1);
        instr_retire = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        do_reset();
        irq = 1'b0; mret = 1'b1;
        repeat (4) tick();
        mret = 1'b0;
        csr_expect(2'd0, 32'h0, "post_reset_mstatus");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            irq             = ($urandom_range(0, 3) != 0);
            instr_retire    = ($urandom_range(0, 2) == 0);
            mret            = ($urandom_range(0, 3) == 0);
            csr_we          = ($urandom_range(0, 7) == 0);
            csr_sel         = 2'($urandom_range(0, 3));
            csr_wdata       = $urandom;
            isr_addr        = $urandom;
            pc_next         = $urandom;
            priority_select = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) do_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 Parameter: ADDR_W, default 32, width of all address and CSR data paths.
REQ-002 Parameter: HOLDOFF, default 2, cycles after IACK or return during which irq is ignored (range 1..15).
REQ-003 Timing/reset: one clock, clk, rising edge; reset rst_n is asynchronous and active-low.
REQ-004 Port: clk  in  1  system clock.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: irq  in  1  interrupt request from interrupt controller.
REQ-007 Port: isr_addr  in  ADDR_W  vector of highest-priority pending source.
REQ-008 Port: priority_select  in  2  index of that source.
REQ-009 Port: pc_next  in  ADDR_W  address of next instruction to execute.
REQ-010 Port: instr_retire  in  1  instruction boundary reached this cycle.
REQ-011 Port: mret  in  1  return-from-interrupt instruction retired.
REQ-012 Port: csr_we  in  1  CSR write strobe.
REQ-013 Port: csr_sel  in  2  CSR index (0 mstatus, 1 mepc, 2 mcause, 3 mtarget).
REQ-014 Port: csr_wdata  in  ADDR_W  CSR write data.
REQ-015 Port: csr_rdata  out  ADDR_W  combinational read of csr_sel.
REQ-016 Port: iack  out  1  one-cycle acknowledge to interrupt controller.
REQ-017 Port: pc_redirect  out  1  one-cycle fetch redirect strobe.
REQ-018 Port: redirect_addr  out  ADDR_W  redirect target, valid with pc_redirect.
REQ-019 Port: stall_fetch  out  1  hold fetch while draining to a boundary.
REQ-020 Port: in_isr  out  1  handler executing.

Function
REQ-021 FSM states: IDLE, DRAIN, VECTOR, ISR, RETURN.
REQ-022 IDLE -> DRAIN when irq=1, mstatus.MIE=1 and holdoff count=0; stall_fetch=1 throughout DRAIN.
REQ-023 DRAIN -> VECTOR on instr_retire=1; that edge latches mepc<=pc_next, mcause<=priority_select (zero-extended), mtarget<=isr_addr, MPIE<=MIE, MIE<=0.
REQ-024 DRAIN -> IDLE without latching if irq drops or MIE is cleared by CSR write before instr_retire; stall_fetch deasserts next cycle.
REQ-025 VECTOR lasts exactly one cycle: iack=1, pc_redirect=1, redirect_addr=mtarget; then ISR and holdoff loads HOLDOFF.
REQ-026 ISR: in_isr=1; irq ignored (no nesting); mret=1 -> RETURN.
REQ-027 RETURN lasts one cycle: pc_redirect=1, redirect_addr=mepc, MIE<=MPIE, MPIE<=1; then IDLE with holdoff reloaded to HOLDOFF.
REQ-028 Holdoff counter decrements by 1 per cycle to 0 and saturates; irq sampled only at 0.
REQ-029 mret outside ISR is ignored: no redirect, no CSR change.
REQ-030 mstatus: bit0 MIE, bit1 MPIE, other bits read 0 and ignore writes; mepc, mcause writable; mtarget read-only.
REQ-031 Hardware CSR updates (REQ-023, REQ-027) win over a same-cycle csr_we to the same field.
REQ-032 iack and pc_redirect never assert for more than one consecutive cycle and never outside VECTOR/RETURN.

Reset
REQ-033 While rst_n=0: state IDLE, MIE=0, MPIE=0, mepc=mcause=mtarget=0, holdoff=0.
REQ-034 Reset outputs: iack=0, pc_redirect=0, redirect_addr=0, stall_fetch=0, in_isr=0, csr_rdata reflects zeroed CSRs.
REQ-035 Reset asserted mid-DRAIN/VECTOR/ISR aborts immediately; no iack or redirect issued after release until a new take.

Structure
REQ-036 Shared package holds FSM state enum, CSR index constants, mstatus bit positions.
REQ-037 One sub-module, irq_holdoff_cnt: 4-bit loadable down-counter with zero flag.

Verification
REQ-038 Take: MIE=1, irq=1, isr_addr=0x100, priority_select=2, pc_next=0x40, instr_retire after 3 cycles -> stall 3 cycles, one-cycle iack+redirect to 0x100, mepc=0x40, mcause=2, MIE=0, MPIE=1.
REQ-039 Return: in ISR, mret=1 -> one-cycle redirect to 0x40, MIE=1, IDLE; irq held high ignored for 2 cycles, retaken on 3rd.
REQ-040 Abort: irq drops during DRAIN -> back to IDLE, no iack, mepc unchanged.
REQ-041 Masked: MIE=0, irq=1 for 20 cycles -> no stall, no iack; write mstatus=1 -> take starts next cycle.
REQ-042 Collision: csr_we writes mstatus=1 in the DRAIN->VECTOR edge cycle -> MIE reads 0 afterwards.
REQ-043 Reset mid-ISR -> all outputs 0, MIE=0, stray mret after release -> no redirect.
